// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: synchronises the PLL lock flag and releases per-domain resets in staggered order.
// Optional lock-loss glitch filter is enabled by defining RST_SEQ_GLITCH_FILTER_EN.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int GLITCH_CYCLES  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_locked,
    input  logic                   i_sw_rst,
    input  logic                   i_clr_status,
    output logic [NUM_DOMAINS-1:0] o_rst,
    output logic                   o_ready,
    output logic                   o_lock_lost,
    output logic [1:0]             o_state
);
    localparam int MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_C  = (MAX_HS > GLITCH_CYCLES) ? MAX_HS : GLITCH_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0]          CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]          CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES - 32'sd1);
    localparam logic [CW-1:0]          STAG_LAST = CW'(STAGGER_CYCLES - 32'sd1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ON    = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] ALL_OFF   = {NUM_DOMAINS{1'b0}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [NUM_DOMAINS-1:0] r_rst;
    logic [NUM_DOMAINS-1:0] w_rst_nxt;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic                   w_lock_lost_nxt;
    logic                   w_active;
    logic                   w_loss_det;
    logic                   w_loss;

    assign w_lk     = r_sync[SYNC_STAGES-1];
    assign w_active = (r_state == ST_RELEASE) || (r_state == ST_RUN);

`ifdef RST_SEQ_GLITCH_FILTER_EN
    localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 32'sd1);
    logic [CW-1:0] r_gcnt;
    logic [CW-1:0] w_gcnt_nxt;

    assign w_loss_det = w_active && !w_lk && (r_gcnt == GLITCH_LAST);

    // Count consecutive low lk samples while sequencing; any lk=1 or state change restarts it.
    always_comb begin
        w_gcnt_nxt = CNT_ZERO;
        if (w_active && !w_lk && (w_state_nxt == r_state)) begin
            w_gcnt_nxt = r_gcnt + CNT_ONE;
        end else begin
            w_gcnt_nxt = CNT_ZERO;
        end
    end

    // Glitch filter counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gcnt <= CNT_ZERO;
        end else begin
            r_gcnt <= w_gcnt_nxt;
        end
    end
`else
    assign w_loss_det = w_active && !w_lk;
`endif

    // Next-state, counter and reset-vector logic; released domains are always the low bits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_nxt   = r_rst;
        w_loss      = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_rst_nxt = ALL_ON;
                w_cnt_nxt = CNT_ZERO;
                if (w_lk) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_HOLD: begin
                if (!w_lk) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rst_nxt   = ALL_ON;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rst_nxt   = ALL_ON << 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_rst_nxt   = ALL_ON;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (w_loss_det) begin
                    w_loss      = 1'b1;
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rst_nxt   = ALL_ON;
                end else if (i_sw_rst) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rst_nxt   = ALL_ON;
                end else if (r_state == ST_RELEASE) begin
                    // A due release waits (counter saturated) while lk is low.
                    if (r_cnt != STAG_LAST) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end else if (!w_lk) begin
                        w_cnt_nxt = r_cnt;
                    end else if (r_rst == ALL_OFF) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_rst_nxt   = r_rst << 1'b1;
                    end
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                    w_rst_nxt = ALL_OFF;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = CNT_ZERO;
                w_rst_nxt   = ALL_ON;
            end
        endcase
    end

    // Sticky lock-lost flag: a new loss wins over a simultaneous clear.
    always_comb begin
        if (w_loss) begin
            w_lock_lost_nxt = 1'b1;
        end else if (i_clr_status) begin
            w_lock_lost_nxt = 1'b0;
        end else begin
            w_lock_lost_nxt = r_lock_lost;
        end
    end

    // Synchroniser, state, counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= {SYNC_STAGES{1'b0}};
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= CNT_ZERO;
            r_rst       <= ALL_ON;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_locked};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rst       <= w_rst_nxt;
            r_ready     <= (w_state_nxt == ST_RUN);
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign o_rst       = r_rst;
    assign o_ready     = r_ready;
    assign o_lock_lost = r_lock_lost;
    assign o_state     = r_state;

endmodule
